// File: rtl/definitions.sv
// Shared core definitions: memory-operation encoding plus load/store unit types.
package definitions;

   typedef enum logic [2:0] {
      ld_byte_s, ld_byte_u, ld_half_s, ld_half_u, ld_word,
      str_byte, str_half_word, str_word
   } mem_operation_t;

   typedef enum logic [2:0] {IDLE, REQ1, WAIT1, REQ2, WAIT2, RESP} lsu_state_t;

   localparam logic [3:0] BE_BYTE = 4'b0001;
   localparam logic [3:0] BE_HALF = 4'b0011;
   localparam logic [3:0] BE_WORD = 4'b1111;

   typedef struct packed {
      mem_operation_t op;
      logic [31:0]    addr;
      logic [31:0]    wdata;
   } lsu_req_t;

   // Unshifted lane mask for the access size.
   function automatic logic [3:0] op_be(input mem_operation_t op);
      case (op)
         ld_byte_s, ld_byte_u, str_byte:      return BE_BYTE;
         ld_half_s, ld_half_u, str_half_word: return BE_HALF;
         default:                             return BE_WORD;
      endcase
   endfunction

   function automatic logic op_is_store(input mem_operation_t op);
      return (op == str_byte) || (op == str_half_word) || (op == str_word);
   endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Execute-side request/response handshake and data-memory bus of the load/store unit.
interface load_store_unit_if;
   import definitions::*;

   logic           req_valid;
   logic           req_ready;
   mem_operation_t mem_op;
   logic [31:0]    addr;
   logic [31:0]    wdata;
   logic           rsp_valid;
   logic [31:0]    rsp_rdata;
   logic           rsp_err;
   logic           mem_req;
   logic           mem_we;
   logic [29:0]    mem_addr;
   logic [3:0]     mem_be;
   logic [31:0]    mem_wdata;
   logic           mem_gnt;
   logic           mem_rvalid;
   logic [31:0]    mem_rdata;

   // slave: the LSU itself; master: execute stage plus data memory around it
   modport slave (
      input  req_valid, mem_op, addr, wdata, mem_gnt, mem_rvalid, mem_rdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
             mem_req, mem_we, mem_addr, mem_be, mem_wdata
   );
   modport master (
      output req_valid, mem_op, addr, wdata, mem_gnt, mem_rvalid, mem_rdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
             mem_req, mem_we, mem_addr, mem_be, mem_wdata
   );
endinterface

// File: rtl/lsu_data_align.sv
// Combinational lane alignment: byte enables and store shifting for both beats,
// plus load extraction and sign/zero extension from the {beat2, beat1} pair.
module lsu_data_align
   import definitions::*;
(
   input  mem_operation_t op,
   input  logic [1:0]     off,
   input  logic [31:0]    wdata,
   input  logic [31:0]    beat1,
   input  logic [31:0]    beat2,
   output logic [3:0]     be1,
   output logic [3:0]     be2,
   output logic [31:0]    wdata1,
   output logic [31:0]    wdata2,
   output logic           split,
   output logic           misaligned,
   output logic [31:0]    rdata
);
   logic [4:0]  sh;
   logic [7:0]  be_pair;
   logic [63:0] wd_pair;
   logic [31:0] rd_word;

   assign sh = {off, 3'b000};

   // Lanes shifted past bit 3 spill into the following word
   assign be_pair         = {4'b0000, op_be(op)} << off;
   assign {be2, be1}      = be_pair;
   assign wd_pair         = {32'h0, wdata} << sh;
   assign {wdata2, wdata1} = wd_pair;
   assign split           = |be2;
   assign misaligned      = ((op_be(op) == BE_HALF) && off[0]) ||
                            ((op_be(op) == BE_WORD) && (off != 2'b00));
   assign rd_word         = 32'({beat2, beat1} >> sh);

   always_comb begin
      rdata = '0;
      unique case (op)
         ld_byte_s: rdata = {{24{rd_word[7]}}, rd_word[7:0]};
         ld_byte_u: rdata = {24'h0, rd_word[7:0]};
         ld_half_s: rdata = {{16{rd_word[15]}}, rd_word[15:0]};
         ld_half_u: rdata = {16'h0, rd_word[15:0]};
         ld_word:   rdata = rd_word;
         default:   rdata = '0;
      endcase
   end
endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one access per handshake onto a word bus with grant/valid beats.
// Define LSU_MISALIGNED_SPLIT_EN to perform misaligned accesses (two beats when crossing a word).
module load_store_unit
   import definitions::*;
#(
   parameter int DATA_W = 32
) (
   input logic              clk,
   input logic              rstN,
   load_store_unit_if.slave bus
);
`ifdef LSU_MISALIGNED_SPLIT_EN
   localparam bit SPLIT_EN = 1'b1;
`else
   localparam bit SPLIT_EN = 1'b0;
`endif

   lsu_state_t        state, state_nxt;
   lsu_req_t          req_q, req_cur;
   logic [DATA_W-1:0] beat1_q, beat1, ld_data, wdata1, wdata2;
   logic [3:0]        be1, be2;
   logic              split, misaligned, reject, need_split;
   logic              enter_req1, enter_req2, enter_resp;

   // In IDLE the live request drives alignment so REQ1 fields are ready on entry
   always_comb begin
      req_cur = req_q;
      if (state == IDLE) begin
         req_cur.op    = bus.mem_op;
         req_cur.addr  = bus.addr;
         req_cur.wdata = bus.wdata;
      end
   end

   assign beat1 = (state == WAIT1) ? bus.mem_rdata : beat1_q;

   lsu_data_align u_align (
      .op(req_cur.op), .off(req_cur.addr[1:0]), .wdata(req_cur.wdata),
      .beat1(beat1), .beat2(bus.mem_rdata),
      .be1(be1), .be2(be2), .wdata1(wdata1), .wdata2(wdata2),
      .split(split), .misaligned(misaligned), .rdata(ld_data)
   );

   assign reject        = misaligned && !SPLIT_EN;
   assign need_split    = split && SPLIT_EN;
   assign bus.req_ready = (state == IDLE);

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (bus.req_valid)  state_nxt = reject ? RESP : REQ1;
         REQ1:    if (bus.mem_gnt)    state_nxt = WAIT1;
         WAIT1:   if (bus.mem_rvalid) state_nxt = need_split ? REQ2 : RESP;
         REQ2:    if (bus.mem_gnt)    state_nxt = WAIT2;
         WAIT2:   if (bus.mem_rvalid) state_nxt = RESP;
         RESP:                        state_nxt = IDLE;
         default:                     state_nxt = IDLE;
      endcase
   end

   assign enter_req1 = (state_nxt == REQ1) && (state != REQ1);
   assign enter_req2 = (state_nxt == REQ2) && (state != REQ2);
   assign enter_resp = (state_nxt == RESP);

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         req_q         <= '0;
         beat1_q       <= '0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_err   <= 1'b0;
         bus.rsp_rdata <= '0;
         bus.mem_req   <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_be    <= '0;
         bus.mem_wdata <= '0;
      end else begin
         if ((state == IDLE) && bus.req_valid) req_q   <= req_cur;
         if ((state == WAIT1) && bus.mem_rvalid) beat1_q <= bus.mem_rdata;
         bus.rsp_valid <= enter_resp;
         bus.mem_req   <= (state_nxt == REQ1) || (state_nxt == REQ2);
         if (enter_req1) begin
            bus.mem_we    <= op_is_store(req_cur.op);
            bus.mem_addr  <= req_cur.addr[DATA_W-1:2];
            bus.mem_be    <= be1;
            bus.mem_wdata <= wdata1;
         end
         // Second beat targets the next word; the 30-bit add wraps on its own
         if (enter_req2) begin
            bus.mem_addr  <= req_q.addr[DATA_W-1:2] + 30'd1;
            bus.mem_be    <= be2;
            bus.mem_wdata <= wdata2;
         end
         // RESP is entered straight from IDLE only for a rejected access
         if (enter_resp) begin
            bus.rsp_err   <= (state == IDLE);
            bus.rsp_rdata <= (state == IDLE) ? '0 : ld_data;
         end
      end
   end
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, reset corner case,
// and random accesses against a byte-addressed memory reference model.
module tb_load_store_unit;
   import definitions::*;

   logic clk;
   logic rstN;
   int   checks   = 0;
   int   failures = 0;

   load_store_unit_if bus();

   load_store_unit #(.DATA_W(32)) dut (.clk(clk), .rstN(rstN), .bus(bus.slave));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   // Bus-side word memory (serviced from mem_* beats) and byte-level reference image
   logic [31:0] wmem [logic [29:0]];
   logic [7:0]  bmem [logic [31:0]];

   int          nbeats;
   int          stable_errs = 0;
   logic [29:0] bt_ma [2];
   logic [3:0]  bt_be [2];
   logic [31:0] bt_wd [2];
   logic        bt_we [2];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] dflt_word(input logic [29:0] w);
      return {w, 2'b00} ^ 32'hA5C3_0F69 ^ ({w, 2'b00} << 7);
   endfunction

   function automatic logic [7:0] ref_byte(input logic [31:0] a);
      logic [31:0] w;
      if (bmem.exists(a)) return bmem[a];
      w = dflt_word(a[31:2]);
      return w[8*a[1:0] +: 8];
   endfunction

   function automatic void preload(input logic [29:0] w, input logic [31:0] val);
      wmem[w] = val;
      for (int i = 0; i < 4; i++) bmem[{w, 2'(i)}] = val[8*i +: 8];
   endfunction

   function automatic int op_bytes(input mem_operation_t op);
      case (op)
         ld_byte_s, ld_byte_u, str_byte:      return 1;
         ld_half_s, ld_half_u, str_half_word: return 2;
         default:                             return 4;
      endcase
   endfunction

   // Reference: little-endian byte memory; returns expected result and beat count, applies stores
   function automatic void ref_access(input mem_operation_t op, input logic [31:0] a,
                                      input logic [31:0] wd, output logic [31:0] rd,
                                      output logic er, output int beats);
      int n   = op_bytes(op);
      int off = int'(a[1:0]);
      bit st  = (op == str_byte) || (op == str_half_word) || (op == str_word);
`ifdef LSU_MISALIGNED_SPLIT_EN
      er = 1'b0;
`else
      er = ((n == 2) && a[0]) || ((n == 4) && (off != 0));
`endif
      rd    = '0;
      beats = er ? 0 : ((off + n > 4) ? 2 : 1);
      if (!er) begin
         if (st) begin
            for (int i = 0; i < n; i++) bmem[a + 32'(i)] = wd[8*i +: 8];
         end else begin
            for (int i = 0; i < n; i++) rd[8*i +: 8] = ref_byte(a + 32'(i));
            if (op == ld_byte_s) rd = {{24{rd[7]}}, rd[7:0]};
            if (op == ld_half_s) rd = {{16{rd[15]}}, rd[15:0]};
         end
      end
   endfunction

   // Issue one access and play the memory: grant after gdly REQ cycles, rvalid after rdly WAIT cycles
   task automatic access(input mem_operation_t op, input logic [31:0] a, input logic [31:0] wd,
                         input int gdly, input int rdly, input bit noise,
                         output logic [31:0] rd, output logic er, output int lat);
      int          cyc, gcnt, rcnt;
      bit          pending, done, holding;
      logic [31:0] rword, cur;
      logic [29:0] w;
      logic [66:0] hold;
      nbeats = 0;
      rd = 'x; er = 'x; lat = -1;
      @(negedge clk);
      chk("req_ready_idle", bus.req_ready, 1);
      bus.req_valid = 1'b1; bus.mem_op = op; bus.addr = a; bus.wdata = wd;
      @(negedge clk);
      bus.req_valid = 1'b0; bus.addr = $urandom; bus.wdata = $urandom;
      cyc = 1; done = 0; pending = 0; gcnt = 0; rcnt = 0; holding = 0;
      rword = '0; hold = '0;
      while (!done && cyc < 200) begin
         bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = $urandom;
         if (bus.rsp_valid) begin
            rd = bus.rsp_rdata; er = bus.rsp_err; lat = cyc; done = 1;
         end else begin
            if (bus.mem_req) begin
               if (holding && (hold != {bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata}))
                  stable_errs++;
               hold = {bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata};
               holding = 1;
               if (gcnt < gdly) begin
                  gcnt++;
                  if (noise && ($urandom_range(1) == 1)) bus.mem_rvalid = 1'b1;
               end else begin
                  bus.mem_gnt = 1'b1;
                  if (nbeats < 2) begin
                     bt_ma[nbeats] = bus.mem_addr; bt_be[nbeats] = bus.mem_be;
                     bt_wd[nbeats] = bus.mem_wdata; bt_we[nbeats] = bus.mem_we;
                  end
                  nbeats++;
                  w   = bus.mem_addr;
                  cur = wmem.exists(w) ? wmem[w] : dflt_word(w);
                  if (bus.mem_we) begin
                     for (int i = 0; i < 4; i++)
                        if (bus.mem_be[i]) cur[8*i +: 8] = bus.mem_wdata[8*i +: 8];
                     wmem[w] = cur;
                     rword   = '0;
                  end else rword = cur;
                  pending = 1; gcnt = 0; rcnt = 0; holding = 0;
               end
            end else if (pending) begin
               if (rcnt < rdly) begin
                  rcnt++;
                  if (noise && ($urandom_range(1) == 1)) bus.mem_gnt = 1'b1;
               end else begin
                  bus.mem_rvalid = 1'b1; bus.mem_rdata = rword; pending = 0;
               end
            end
            @(negedge clk);
            cyc++;
         end
      end
      bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
      if (!done) begin
         checks++; failures++;
         $display("FAIL timeout: no rsp_valid within %0d cycles for addr %h", cyc, a);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_req_ready"}, bus.req_ready, 1);
      chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
      chk({tag, "_rsp_err"},   bus.rsp_err, 0);
      chk({tag, "_rsp_rdata"}, bus.rsp_rdata, 0);
      chk({tag, "_mem_req"},   bus.mem_req, 0);
      chk({tag, "_mem_we"},    bus.mem_we, 0);
      chk({tag, "_mem_be"},    bus.mem_be, 0);
      chk({tag, "_mem_addr"},  bus.mem_addr, 0);
      chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
   endtask

   typedef struct {
      mem_operation_t op;
      logic [31:0]    addr, wdata, pre1, pre2, exp_rd;
      logic           exp_err;
      int             exp_beats;
      logic [3:0]     be1, be2;
      logic [29:0]    ma1, ma2;
      logic [31:0]    wd1, wd2;
      logic           we;
      int             lat;
   } vec_t;

   function automatic vec_t mk(mem_operation_t op, logic [31:0] a, logic [31:0] wd,
                               logic [31:0] p1, logic [31:0] p2, logic [31:0] rd, logic er,
                               int beats, logic [3:0] be1, logic [3:0] be2, logic [29:0] ma1,
                               logic [29:0] ma2, logic [31:0] wd1, logic [31:0] wd2,
                               logic we, int lat);
      vec_t v;
      v.op = op; v.addr = a; v.wdata = wd; v.pre1 = p1; v.pre2 = p2; v.exp_rd = rd;
      v.exp_err = er; v.exp_beats = beats; v.be1 = be1; v.be2 = be2; v.ma1 = ma1;
      v.ma2 = ma2; v.wd1 = wd1; v.wd2 = wd2; v.we = we; v.lat = lat;
      return v;
   endfunction

   initial begin
      vec_t        vecs[$];
      vec_t        v;
      logic [31:0] rd, erd;
      logic        er, eer;
      int          lat, ebeats, elat, bad;
      logic [29:0] w;

      vecs.push_back(mk(ld_word,       32'h100, 0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 1, 4'hF, 0, 30'h40,  0, 0, 0, 0, 3));
      vecs.push_back(mk(ld_byte_s,     32'h203, 0, 32'h80123456, 0, 32'hFFFFFF80, 0, 1, 4'h8, 0, 30'h80,  0, 0, 0, 0, 3));
      vecs.push_back(mk(ld_byte_u,     32'h203, 0, 32'h80123456, 0, 32'h00000080, 0, 1, 4'h8, 0, 30'h80,  0, 0, 0, 0, 3));
      vecs.push_back(mk(str_half_word, 32'h302, 32'h1234ABCD, 0, 0, 0, 0, 1, 4'hC, 0, 30'hC0, 0, 32'hABCD0000, 0, 1, 3));
      vecs.push_back(mk(ld_half_s,     32'h506, 0, 32'h80017777, 0, 32'hFFFF8001, 0, 1, 4'hC, 0, 30'h141, 0, 0, 0, 0, 3));
      vecs.push_back(mk(ld_half_u,     32'h506, 0, 32'h80017777, 0, 32'h00008001, 0, 1, 4'hC, 0, 30'h141, 0, 0, 0, 0, 3));
      vecs.push_back(mk(str_byte,      32'h605, 32'hFFFFFF5A, 0, 0, 0, 0, 1, 4'h2, 0, 30'h181, 0, 32'hFFFF5A00, 0, 1, 3));
      vecs.push_back(mk(str_word,      32'h700, 32'hCAFEF00D, 0, 0, 0, 0, 1, 4'hF, 0, 30'h1C0, 0, 32'hCAFEF00D, 0, 1, 3));
      vecs.push_back(mk(ld_byte_s,     32'h90F, 0, 32'h7F000000, 0, 32'h0000007F, 0, 1, 4'h8, 0, 30'h243, 0, 0, 0, 0, 3));
`ifdef LSU_MISALIGNED_SPLIT_EN
      vecs.push_back(mk(ld_word,   32'h401, 0, 32'h44332211, 32'h88776655, 32'h55443322, 0, 2, 4'hE, 4'h1, 30'h100, 30'h101, 0, 0, 0, 5));
      vecs.push_back(mk(ld_half_u, 32'h801, 0, 32'hAABBCCDD, 0, 32'h0000BBCC, 0, 1, 4'h6, 0, 30'h200, 0, 0, 0, 0, 3));
      vecs.push_back(mk(ld_word,   32'hFFFFFFFD, 0, 32'h44332211, 32'h88776655, 32'h55443322, 0, 2, 4'hE, 4'h1, 30'h3FFFFFFF, 30'h0, 0, 0, 0, 5));
      vecs.push_back(mk(str_word,  32'h903, 32'h11223344, 0, 0, 0, 0, 2, 4'h8, 4'h7, 30'h240, 30'h241, 32'h44000000, 32'h00112233, 1, 5));
`else
      vecs.push_back(mk(ld_word,   32'h401, 0, 32'h44332211, 32'h88776655, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      vecs.push_back(mk(ld_half_u, 32'h801, 0, 32'hAABBCCDD, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      vecs.push_back(mk(ld_word,   32'hFFFFFFFD, 0, 32'h44332211, 32'h88776655, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      vecs.push_back(mk(str_word,  32'h903, 32'h11223344, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
`endif

      rstN = 1'b0;
      bus.req_valid = 1'b0; bus.mem_op = ld_word; bus.addr = '0; bus.wdata = '0;
      bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
      repeat (2) @(negedge clk);
      chk_reset("reset");
      rstN = 1'b1;

      foreach (vecs[i]) begin
         v = vecs[i];
         w = v.addr[31:2];
         preload(w, v.pre1);
         preload(w + 30'd1, v.pre2);
         ref_access(v.op, v.addr, v.wdata, erd, eer, ebeats);  // keeps the byte image in step
         access(v.op, v.addr, v.wdata, 0, 0, 0, rd, er, lat);
         chk($sformatf("vec%0d_rdata", i), rd, v.exp_rd);
         chk($sformatf("vec%0d_err", i), er, v.exp_err);
         chk($sformatf("vec%0d_beats", i), nbeats, v.exp_beats);
         chk($sformatf("vec%0d_latency", i), lat, v.lat);
         if (nbeats > 0 && v.exp_beats > 0) begin
            chk($sformatf("vec%0d_be1", i), bt_be[0], v.be1);
            chk($sformatf("vec%0d_addr1", i), bt_ma[0], v.ma1);
            chk($sformatf("vec%0d_wdata1", i), bt_wd[0], v.wd1);
            chk($sformatf("vec%0d_we", i), bt_we[0], v.we);
         end
         if (nbeats > 1 && v.exp_beats > 1) begin
            chk($sformatf("vec%0d_be2", i), bt_be[1], v.be2);
            chk($sformatf("vec%0d_addr2", i), bt_ma[1], v.ma2);
            chk($sformatf("vec%0d_wdata2", i), bt_wd[1], v.wd2);
         end
      end

      // Grant withheld 5 cycles, then reset while waiting for the read beat
      preload(30'h40, 32'h0DDC0FFE);
      @(negedge clk);
      bus.req_valid = 1'b1; bus.mem_op = ld_word; bus.addr = 32'h100;
      @(negedge clk);
      bus.req_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("hold_mem_req", bus.mem_req, 1);
         chk("hold_mem_addr", bus.mem_addr, 30'h40);
         chk("hold_req_ready", bus.req_ready, 0);
         @(negedge clk);
      end
      bus.mem_gnt = 1'b1;
      @(negedge clk);
      bus.mem_gnt = 1'b0;
      chk("wait1_mem_req", bus.mem_req, 0);
      #2 rstN = 1'b0;
      #1 chk_reset("midrst");
      @(negedge clk);
      rstN = 1'b1;
      bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0BAD0BAD;
      @(negedge clk);
      bus.mem_rvalid = 1'b0;
      chk("stray_rvalid_rsp", bus.rsp_valid, 0);
      chk("stray_rvalid_ready", bus.req_ready, 1);
      ref_access(ld_word, 32'h100, 0, erd, eer, ebeats);
      access(ld_word, 32'h100, 0, 0, 0, 0, rd, er, lat);
      chk("postrst_rdata", rd, erd);
      chk("postrst_latency", lat, 3);

      // Random accesses with random bus delays and spurious gnt/rvalid pulses
      for (int k = 0; k < 300; k++) begin
         mem_operation_t op;
         logic [31:0]    a, wd;
         int             g, r;
         op = mem_operation_t'($urandom_range(0, 7));
         a  = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF8 + $urandom_range(0, 7)
                                          : 32'h1000 + $urandom_range(0, 31);
         wd = $urandom;
         g  = $urandom_range(0, 3);
         r  = $urandom_range(0, 3);
         ref_access(op, a, wd, erd, eer, ebeats);
         elat = eer ? 1 : (ebeats == 1 ? 3 + g + r : 5 + 2 * g + 2 * r);
         access(op, a, wd, g, r, 1, rd, er, lat);
         chk($sformatf("rnd%0d_rdata", k), rd, erd);
         chk($sformatf("rnd%0d_err", k), er, eer);
         chk($sformatf("rnd%0d_beats", k), nbeats, ebeats);
         chk($sformatf("rnd%0d_latency", k), lat, elat);
      end

      chk("bus_fields_stable", stable_errs, 0);
      bad = 0;
      foreach (bmem[a]) begin
         logic [31:0] mw;
         mw = wmem.exists(a[31:2]) ? wmem[a[31:2]] : dflt_word(a[31:2]);
         if (mw[8*a[1:0] +: 8] !== bmem[a]) bad++;
      end
      chk("memory_image", bad, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage of the RISC-V core: accepts one load/store per handshake from the execute stage, encoded as `mem_operation_t` with byte address and store data. Drives a word-wide data-memory bus with grant/valid handshakes and byte-lane alignment. Returns sign/zero-extended load data or a store acknowledge to writeback. Sits between the ALU/execute stage and the data memory.

## Interface
- `DATA_W`, 32: data and address width; only 32 is supported.
- `clk` input 1: clock, rising edge.
- `rstN` input 1: asynchronous active-low reset.
- `req_valid` input 1: execute stage presents an access.
- `req_ready` output 1: LSU can accept an access.
- `mem_op` input 3 (`mem_operation_t`): access kind.
- `addr` input 32: byte address.
- `wdata` input 32: store data, right-justified.
- `rsp_valid` output 1: one-cycle result pulse.
- `rsp_rdata` output 32: extended load data; 0 for stores.
- `rsp_err` output 1: misaligned access rejected; valid with `rsp_valid`.
- `mem_req` output 1: bus request.
- `mem_we` output 1: bus write.
- `mem_addr` output 30: word address, byte address bits [31:2].
- `mem_be` output 4: byte enables.
- `mem_wdata` output 32: lane-aligned write data.
- `mem_gnt` input 1: bus accepted the request this cycle.
- `mem_rvalid` input 1: response beat; read data for loads, ack for stores.
- `mem_rdata` input 32: read data.

## Operation
- FSM states: IDLE, REQ1, WAIT1, REQ2, WAIT2, RESP.
- IDLE: `req_ready`=1. On accept, register op, addr and wdata.
  - Misaligned and not supported: go to RESP with `rsp_err`=1; no bus activity.
  - Otherwise go to REQ1.
- REQ1/REQ2: `mem_req`=1, with bus fields held stable until `mem_gnt`. On `mem_gnt`, go to WAIT1/WAIT2.
- WAIT1: on `mem_rvalid`, capture beat. If the access is split, go to REQ2; otherwise go to RESP.
- WAIT2: on `mem_rvalid`, capture beat and go to RESP.
- RESP: `rsp_valid`=1 for one cycle, then IDLE.
- Offset `off` = `addr[1:0]`.
  - Byte: `mem_be` = 1<<off.
  - Half: `mem_be` = 3<<off.
  - Word: `mem_be` = 4'hF<<off.
  - Each is truncated to 4 bits in beat 1. The overflow bits form beat 2's enables at `mem_addr`+1, which wraps modulo 2^30.
- `mem_wdata` = `wdata`<<(8·off) in beat 1. Beat 2 carries `wdata`>>(8·(4−off)).
- Load assembly: {beat2, beat1} >> (8·off), truncated to size.
  - `_s` ops sign-extend; `_u` ops zero-extend.
  - Store ops are never sign-related.
- `mem_rvalid` arriving outside WAIT1/WAIT2 is ignored. `mem_gnt` outside REQ states is ignored.

## Timing
- Reset (asynchronous): state IDLE.
  - `req_ready`=1.
  - `rsp_valid`, `rsp_err`, `mem_req`, `mem_we`=0.
  - `mem_be`=0, `mem_addr`=0, `mem_wdata`=0, `rsp_rdata`=0.
- Reset mid-transaction abandons it. Any later `mem_rvalid` is ignored.
- Minimum latency, aligned access with `mem_gnt` in REQ1 and `mem_rvalid` the next cycle:
  - accept at cycle 0, `mem_req` at cycle 1, `mem_rvalid` at cycle 2, `rsp_valid` at cycle 3.
- Split access adds 2 cycles minimum.
- Throughput: one access per 4 cycles at best. `req_ready`=0 in all non-IDLE states.
- Bus outputs are registered. They change only on state entry.

## Configuration
- `LSU_MISALIGNED_SPLIT_EN` defined:
  - Any misaligned half/word access is performed.
  - Accesses that stay within a word use one beat.
  - Accesses crossing a word boundary use two beats: half at off=3; word at off≠0.
  - `rsp_err` is never set.
- Undefined:
  - Half with `addr[0]`=1 or word with `addr[1:0]`≠0 is rejected with `rsp_err`=1 and `rsp_rdata`=0.
  - REQ2/WAIT2 are unreachable and may be optimized away.

## Structure
- `mem_operation_t` stays in the shared `definitions` package.
- Add to that package:
  - `lsu_state_t` enum.
  - Byte-enable constants `BE_BYTE`=4'b0001, `BE_HALF`=4'b0011, `BE_WORD`=4'b1111.
- Sub-module `lsu_data_align`: combinational store lane shifting, byte-enable generation, and load extraction/extension. The FSM lives in `load_store_unit`.

## Test plan
- ld_word at 0x100, `mem_rdata`=0xDEADBEEF, gnt immediate, rvalid +1 → `rsp_rdata`=0xDEADBEEF at cycle 3; `mem_be`=4'hF, `mem_addr`=0x40.
- ld_byte_s at 0x203, rdata 0x80xxxxxx → 0xFFFFFF80. ld_byte_u at the same address → 0x00000080.
- str_half_word at 0x302, wdata 0x1234ABCD → `mem_be`=4'b1100, `mem_wdata`=0xABCD0000, `mem_we`=1.
- ld_word at 0x401 with split enabled:
  - beat 1 `be`=4'b1110, rdata 0x44332211.
  - beat 2 at word 0x101, `be`=4'b0001, rdata 0x88776655.
  - result 0x55443322.
- Same access with split disabled → `rsp_err`=1 at cycle 1, no `mem_req`.
- `mem_gnt` withheld 5 cycles, then `rstN` pulsed while in WAIT1 → all outputs at reset values; the next request proceeds normally.
